core_pipe_lsu: RTL and testbench

Load/store unit between the execute stage and mem_sram_axi_master. It accepts one load/store request at a time and decodes RV32 funct3 into access size and sign rule. It drives the master's en/wen/addr/size/din control port and waits for done. Load data is sign- or zero-extended, and the result or store completion goes to writeback over a valid/ready handshake.

---
 rtl/core_lsu_defs.sv | 40 ++++
 rtl/core_lsu_extend.sv | 31 +++
 rtl/core_pipe_lsu.sv | 213 +++++++++++++++++++++
 tb/tb_core_pipe_lsu.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_defs.sv
// -----------------------------------------------------------------------------
// core_lsu_defs
// Shared definitions for the core load/store unit:
//   - RV32 load/store funct3 encodings (F3_B/H/W/BU/HU)
//   - memory-master access size encodings (SIZE_B/H/W)
//   - LSU FSM state encoding
//   - f3_size(): funct3 -> access size
// -----------------------------------------------------------------------------
package core_lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    // Low two funct3 bits give the access width for every legal encoding;
    // the 2'b11 pattern is always illegal and is mapped to byte only so the
    // result stays a valid size code.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3[1:0])
            2'b01:   sz = SIZE_H;
            2'b10:   sz = SIZE_W;
            default: sz = SIZE_B;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/core_lsu_extend.sv
// -----------------------------------------------------------------------------
// core_lsu_extend
// Combinational load-data extender driven by RV32 funct3.
//   funct3 in : LB/LH sign-extend, LBU/LHU zero-extend, anything else passes
//               the raw value through unchanged (LW).
//   raw    in : right-justified data
//   ext    out: extended result
// Also used with the unsigned byte/half codes to mask store data.
// -----------------------------------------------------------------------------
module core_lsu_extend
    import core_lsu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
            F3_H:    ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_BU:   ext = {{(XLEN-8){1'b0}}, raw[7:0]};
            F3_HU:   ext = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/core_pipe_lsu.sv
// -----------------------------------------------------------------------------
// core_pipe_lsu
// Load/store unit between the execute stage and mem_sram_axi_master.
// Accepts one request at a time, drives the master control port, waits for
// mem_done, extends load data and hands the result to writeback.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_wen, req_funct3        1=store / 0=load, RV32 funct3
//   req_addr, req_wdata        byte address, store data
//   req_rd                     load destination register
//   rsp_valid/rsp_ready        writeback handshake
//   rsp_data, rsp_rd           extended load data (0 for stores/errors), rd
//   rsp_we, rsp_err            register write enable, misaligned/illegal op
//   mem_en, mem_wen            master enable / write enable
//   mem_addr, mem_size         master address, size (00 B, 01 H, 10 W)
//   mem_din, mem_dout          store data out, load data in (right-justified)
//   mem_done                   single-cycle completion pulse from master
//
// Build option CORE_LSU_MISALIGN_CHECK_EN:
//   defined   - misaligned half/word accesses return rsp_err without touching
//               memory
//   undefined - address low bits are cleared to the access alignment and the
//               access proceeds; only illegal funct3 raises rsp_err
// -----------------------------------------------------------------------------
module core_pipe_lsu
    import core_lsu_defs::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [RD_W-1:0] rsp_rd,
    output logic            rsp_we,
    output logic            rsp_err,
    output logic            mem_en,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_din,
    input  logic [XLEN-1:0] mem_dout,
    input  logic            mem_done
);

    lsu_state_e      state_q, state_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic [XLEN-1:0] din_q, din_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_we_q, rsp_we_d;
    logic            rsp_err_q, rsp_err_d;

    logic            legal_f3;
    logic            req_err;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr_eff;
    logic [2:0]      st_f3;
    logic [XLEN-1:0] st_din;
    logic [XLEN-1:0] ld_ext;

    // Store masking reuses the extender with the unsigned byte/half codes;
    // SW maps to 3'b110, which the extender passes through untouched.
    assign st_f3 = {1'b1, req_funct3[1:0]};

    core_lsu_extend #(.XLEN(XLEN)) u_st_mask (
        .funct3 (st_f3),
        .raw    (req_wdata),
        .ext    (st_din)
    );

    core_lsu_extend #(.XLEN(XLEN)) u_ld_ext (
        .funct3 (f3_q),
        .raw    (mem_dout),
        .ext    (ld_ext)
    );

    // Request decode: legality, size and (optionally) alignment.
    always_comb begin
        req_size = f3_size(req_funct3);
        if (req_wen) begin
            legal_f3 = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                       (req_funct3 == F3_W);
        end else begin
            legal_f3 = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                       (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                       (req_funct3 == F3_HU);
        end
`ifdef CORE_LSU_MISALIGN_CHECK_EN
        req_addr_eff = req_addr;
        req_err = !legal_f3 ||
                  ((req_size == SIZE_H) && req_addr[0]) ||
                  ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
`else
        req_addr_eff = req_addr;
        if (req_size == SIZE_H) begin
            req_addr_eff[0] = 1'b0;
        end else if (req_size == SIZE_W) begin
            req_addr_eff[1:0] = 2'b00;
        end
        req_err = !legal_f3;
`endif
    end

    // Next-state and register update logic.
    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        size_d     = size_q;
        din_d      = din_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        rsp_data_d = rsp_data_q;
        rsp_we_d   = rsp_we_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rd_d = req_rd;
                    if (req_err) begin
                        // Errors bypass memory; the master port keeps its
                        // previous (inactive) values.
                        rsp_err_d  = 1'b1;
                        rsp_we_d   = 1'b0;
                        rsp_data_d = '0;
                        state_d    = ST_RESP;
                    end else begin
                        wen_d     = req_wen;
                        addr_d    = req_addr_eff;
                        size_d    = req_size;
                        din_d     = st_din;
                        f3_d      = req_funct3;
                        rsp_err_d = 1'b0;
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_done) begin
                    rsp_data_d = wen_q ? '0 : ld_ext;
                    rsp_we_d   = !wen_q;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            size_q     <= SIZE_B;
            din_q      <= '0;
            rd_q       <= '0;
            f3_q       <= '0;
            rsp_data_q <= '0;
            rsp_we_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            din_q      <= din_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            rsp_data_q <= rsp_data_d;
            rsp_we_q   <= rsp_we_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Handshake and enable outputs decode straight from the state register,
    // so an asserted reset drops mem_en without waiting for a clock.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign mem_en    = (state_q == ST_REQ);

    assign mem_wen  = wen_q;
    assign mem_addr = addr_q;
    assign mem_size = size_q;
    assign mem_din  = din_q;

    assign rsp_data = rsp_data_q;
    assign rsp_rd   = rd_q;
    assign rsp_we   = rsp_we_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_core_pipe_lsu.sv
// -----------------------------------------------------------------------------
// tb_core_pipe_lsu
// Directed bench for core_pipe_lsu. The bench plays execute, the memory master
// and writeback. A reference model derives each op's expected memory request
// and response from byte counts and arithmetic sign extension; a compare
// process checks the DUT against it every cycle, and literal expectations
// after each op pin the model.
// -----------------------------------------------------------------------------
module tb_core_pipe_lsu;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [RD_W-1:0] req_rd;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [RD_W-1:0] rsp_rd;
    logic            rsp_we;
    logic            rsp_err;
    logic            mem_en;
    logic            mem_wen;
    logic [XLEN-1:0] mem_addr;
    logic [1:0]      mem_size;
    logic [XLEN-1:0] mem_din;
    logic [XLEN-1:0] mem_dout;
    logic            mem_done;

    always #5 clk = ~clk;

    core_pipe_lsu #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_we     (rsp_we),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_size   (mem_size),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_done   (mem_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected values for the op in flight.
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    logic [31:0] exp_din;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_we;
    logic        exp_err;
    logic        busy = 1'b0;

    // What the DUT presented for the last op.
    logic [31:0] got_addr, got_din, got_data;
    logic [1:0]  got_size;
    logic [4:0]  got_rd;
    logic        got_we, got_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte count from funct3, legality by rule, sign
    // extension by subtracting 2^(8*n) when the field's top bit is set.
    function automatic void model(input logic w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] dout,
                                  output logic err, output logic [1:0] sz,
                                  output logic [31:0] maddr, output logic [31:0] din,
                                  output logic [31:0] data, output logic we);
        int     nb;
        longint fmask, raw;
        bit     legal, mis;
        int     rem;
        case (f3[1:0])
            2'd0:    nb = 1;
            2'd1:    nb = 2;
            2'd2:    nb = 4;
            default: nb = 0;
        endcase
        legal = (nb != 0) && (w ? (f3[2] == 1'b0) : !(f3[2] && nb == 4));
        rem   = (nb != 0) ? int'(a % nb) : 0;
        mis   = (rem != 0);
`ifdef CORE_LSU_MISALIGN_CHECK_EN
        err   = !legal || mis;
        maddr = a;
`else
        err   = !legal;
        maddr = a - 32'(rem);
`endif
        sz    = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        fmask = (longint'(1) << (8 * nb)) - 1;
        din   = 32'(longint'(wd) & fmask);
        raw   = longint'(dout) & fmask;
        if (!f3[2] && nb > 0 && nb < 4 && raw >= (fmask + 1) / 2)
            raw = raw - (fmask + 1);
        data  = (w || err) ? 32'h0 : 32'(raw);
        we    = !w && !err;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready_vs_busy", {31'b0, req_ready}, {31'b0, !busy});
            if (mem_en) begin
                chk("mem_en_on_err_op", {31'b0, exp_err}, 32'h0);
                chk("mem_wen",  {31'b0, mem_wen}, {31'b0, exp_wen});
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_size", {30'b0, mem_size}, {30'b0, exp_size});
                chk("mem_din",  mem_din, exp_din);
            end
            if (rsp_valid) begin
                chk("rsp_data", rsp_data, exp_data);
                chk("rsp_rd",   {27'b0, rsp_rd}, {27'b0, exp_rd});
                chk("rsp_we",   {31'b0, rsp_we}, {31'b0, exp_we});
                chk("rsp_err",  {31'b0, rsp_err}, {31'b0, exp_err});
            end
        end
    end

    task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] dout, input int dly, input int bp);
        logic [31:0] ma, di, da;
        logic [1:0]  sz;
        logic        er, we;
        int          t;
        model(w, f3, a, wd, dout, er, sz, ma, di, da, we);
        exp_wen = w; exp_addr = ma; exp_size = sz; exp_din = di;
        exp_data = da; exp_rd = rd; exp_we = we; exp_err = er;

        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'h1);

        req_valid = 1'b1; req_wen = w; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = 1'b1;

        if (er) begin
            chk("err_mem_en", {31'b0, mem_en}, 32'h0);
            chk("err_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        end else begin
            chk("acc_mem_en", {31'b0, mem_en}, 32'h1);
            chk("acc_rsp_valid", {31'b0, rsp_valid}, 32'h0);
            got_addr = mem_addr; got_size = mem_size; got_din = mem_din;
            repeat (dly) begin
                @(posedge clk); #1;
            end
            mem_dout = dout;
            mem_done = 1'b1;
            @(posedge clk); #1;
            mem_done = 1'b0;
            mem_dout = 32'hDEADBEEF;
            chk("done_mem_en", {31'b0, mem_en}, 32'h0);
            chk("done_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        end
        got_data = rsp_data; got_rd = rsp_rd; got_we = rsp_we; got_err = rsp_err;

        for (int i = 0; i < bp; i++) begin
            mem_done = (i == 0);
            @(posedge clk); #1;
            mem_done = 1'b0;
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        busy = 1'b0;
        chk("hs_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("hs_req_ready", {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0; rsp_ready = 1'b0;
        mem_dout = '0; mem_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data",  rsp_data, 32'h0);
        chk("rst_rsp_rd",    {27'b0, rsp_rd}, 32'h0);
        chk("rst_rsp_we",    {31'b0, rsp_we}, 32'h0);
        chk("rst_rsp_err",   {31'b0, rsp_err}, 32'h0);
        chk("rst_mem_en",    {31'b0, mem_en}, 32'h0);
        chk("rst_mem_wen",   {31'b0, mem_wen}, 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_size",  {30'b0, mem_size}, 32'h0);
        chk("rst_mem_din",   mem_din, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SW then LW of the same word
        do_op(1'b1, 3'b010, 32'h0, 32'hF00FCCAA, 5'd0, 32'h0, 2, 0);
        chk("sw_size", {30'b0, got_size}, 32'h2);
        chk("sw_din",  got_din, 32'hF00FCCAA);
        chk("sw_we",   {31'b0, got_we}, 32'h0);
        chk("sw_err",  {31'b0, got_err}, 32'h0);
        chk("sw_data", got_data, 32'h0);

        do_op(1'b0, 3'b010, 32'h0, 32'h0, 5'd5, 32'hF00FCCAA, 1, 0);
        chk("lw_data", got_data, 32'hF00FCCAA);
        chk("lw_rd",   {27'b0, got_rd}, 32'h5);
        chk("lw_we",   {31'b0, got_we}, 32'h1);

        // Extension
        do_op(1'b0, 3'b000, 32'h10, 32'h0, 5'd1, 32'h000000AA, 0, 1);
        chk("lb_data", got_data, 32'hFFFFFFAA);
        chk("lb_size", {30'b0, got_size}, 32'h0);
        do_op(1'b0, 3'b100, 32'h11, 32'h0, 5'd2, 32'h000000AA, 0, 0);
        chk("lbu_data", got_data, 32'h000000AA);
        chk("lbu_size", {30'b0, got_size}, 32'h0);
        do_op(1'b0, 3'b001, 32'h12, 32'h0, 5'd3, 32'h0000CCAA, 1, 0);
        chk("lh_data", got_data, 32'hFFFFCCAA);
        chk("lh_size", {30'b0, got_size}, 32'h1);
        do_op(1'b0, 3'b101, 32'h14, 32'h0, 5'd4, 32'h0000CCAA, 0, 0);
        chk("lhu_data", got_data, 32'h0000CCAA);
        chk("lhu_size", {30'b0, got_size}, 32'h1);
        do_op(1'b0, 3'b000, 32'h13, 32'h0, 5'd6, 32'h12345680, 0, 0);
        chk("lb_hi_junk", got_data, 32'hFFFFFF80);
        do_op(1'b0, 3'b001, 32'h16, 32'h0, 5'd7, 32'hFFFF7FFF, 0, 0);
        chk("lh_pos", got_data, 32'h00007FFF);

        // Misaligned word load
        do_op(1'b0, 3'b010, 32'h2, 32'h0, 5'd9, 32'h11223344, 0, 0);
`ifdef CORE_LSU_MISALIGN_CHECK_EN
        chk("mis_err",  {31'b0, got_err}, 32'h1);
        chk("mis_we",   {31'b0, got_we}, 32'h0);
        chk("mis_data", got_data, 32'h0);
`else
        chk("mis_addr", got_addr, 32'h0);
        chk("mis_data", got_data, 32'h11223344);
        chk("mis_err",  {31'b0, got_err}, 32'h0);
`endif

        // Store masking
        do_op(1'b1, 3'b000, 32'h3, 32'h11223344, 5'd0, 32'h0, 0, 0);
        chk("sb_din",  got_din, 32'h00000044);
        chk("sb_addr", got_addr, 32'h3);
        do_op(1'b1, 3'b001, 32'h6, 32'hAABBCCDD, 5'd0, 32'h0, 1, 0);
        chk("sh_din",  got_din, 32'h0000CCDD);
        chk("sh_size", {30'b0, got_size}, 32'h1);

        // Illegal funct3
        do_op(1'b0, 3'b011, 32'h0, 32'h0, 5'd10, 32'h0, 0, 0);
        chk("ill_ld011_err", {31'b0, got_err}, 32'h1);
        do_op(1'b0, 3'b110, 32'h0, 32'h0, 5'd11, 32'h0, 0, 1);
        chk("ill_ld110_err", {31'b0, got_err}, 32'h1);
        do_op(1'b1, 3'b100, 32'h0, 32'h55, 5'd0, 32'h0, 0, 0);
        chk("ill_st100_err", {31'b0, got_err}, 32'h1);
        chk("ill_st100_we",  {31'b0, got_we}, 32'h0);

        // Backpressure
        do_op(1'b0, 3'b010, 32'h20, 32'h0, 5'd12, 32'h0BADF00D, 2, 5);
        chk("bp_data", got_data, 32'h0BADF00D);

        // Done pulse while idle is ignored
        mem_done = 1'b1;
        @(posedge clk); #1;
        mem_done = 1'b0;
        chk("idle_done_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("idle_done_mem_en",    {31'b0, mem_en}, 32'h0);

        // Reset during REQ of a store
        exp_wen = 1'b1; exp_addr = 32'h4; exp_size = 2'd2; exp_din = 32'hA5A55A5A;
        exp_rd = 5'd0; exp_err = 1'b0; exp_we = 1'b0; exp_data = 32'h0;
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h4; req_wdata = 32'hA5A55A5A; req_rd = 5'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = 1'b1;
        chk("rst_pre_mem_en", {31'b0, mem_en}, 32'h1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        busy = 1'b0;
        chk("rstmid_mem_en",    {31'b0, mem_en}, 32'h0);
        chk("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rstmid_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rstmid_mem_addr",  mem_addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstrel_req_ready", {31'b0, req_ready}, 32'h1);
        do_op(1'b0, 3'b010, 32'h8, 32'h0, 5'd8, 32'h87654321, 1, 0);
        chk("post_rst_data", got_data, 32'h87654321);
        chk("post_rst_addr", got_addr, 32'h8);
        chk("post_rst_err",  {31'b0, got_err}, 32'h0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
